// File: rtl/sram_dp_be.sv
// Dual-port (one write, one read) single-clock SRAM with per-byte write
// enables, registered read with valid strobe, write-first collision bypass
// and a built-in sequencer that fills every word with INIT_VALUE.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   INIT  | sequencer writes INIT_VALUE to one word per cycle; busy=1,
//         | all user requests ignored
//   READY | user reads/writes served; clr returns to INIT
module sram_dp_be #(
    parameter int                    ADDRESS_BITS = 5,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    NUM_REG      = 32,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cs,
    input  logic                      we,
    input  logic [ADDRESS_BITS-1:0]   wr_addr,
    input  logic [DATA_WIDTH/8-1:0]   wr_be,
    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      rd,
    input  logic [ADDRESS_BITS-1:0]   rd_addr,
    input  logic                      clr,
    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    output logic                      busy
);

    localparam int                      BE_W      = DATA_WIDTH / 8;
    localparam logic [ADDRESS_BITS:0]   DEPTH     = (ADDRESS_BITS + 1)'(NUM_REG);
    localparam logic [ADDRESS_BITS-1:0] LAST_ADDR = ADDRESS_BITS'(NUM_REG - 1);

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDRESS_BITS-1:0] init_ptr;
    logic [DATA_WIDTH-1:0]   mem [NUM_REG];

    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_hit;
    logic                    rd_hit;
    logic [DATA_WIDTH-1:0]   old_word;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Qualify user requests, build the byte-merged write word and the
    // write-first read word (out-of-range reads return zero).
    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH);
        rd_in_range = ({1'b0, rd_addr} < DEPTH);
        wr_hit      = (state == READY) && cs && we && wr_in_range;
        rd_hit      = (state == READY) && cs && rd;
        old_word    = wr_in_range ? mem[wr_addr] : '0;
        merged_word = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (wr_be[i]) begin
                merged_word[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
        rd_word = '0;
        if (rd_in_range) begin
            if (wr_hit && (wr_addr == rd_addr)) begin
                rd_word = merged_word;
            end else begin
                rd_word = mem[rd_addr];
            end
        end
    end

    // Storage array: sequencer fill in INIT, byte-merged user write in READY;
    // untouched while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == INIT) begin
                mem[init_ptr] <= INIT_VALUE;
            end else if (wr_hit) begin
                mem[wr_addr] <= merged_word;
            end
        end
    end

    // Control FSM with registered read port and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b1;
        end else begin
            case (state)
                INIT: begin
                    rd_valid <= 1'b0;
                    if (init_ptr == LAST_ADDR) begin
                        init_ptr <= '0;
                        state    <= READY;
                        busy     <= 1'b0;
                    end else begin
                        init_ptr <= init_ptr + ADDRESS_BITS'(1);
                    end
                end
                READY: begin
                    if (rd_hit) begin
                        rd_data  <= rd_word;
                        rd_valid <= 1'b1;
                    end else begin
                        rd_valid <= 1'b0;
                    end
                    // The same-cycle write and read still complete; the
                    // sequencer then overwrites the whole array.
                    if (clr) begin
                        state    <= INIT;
                        init_ptr <= '0;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state    <= INIT;
                    init_ptr <= '0;
                    rd_valid <= 1'b0;
                    busy     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_dp_be.sv
// Randomised scoreboard bench for sram_dp_be (32-bit words, 20 of 32
// addresses populated, non-zero fill value).
module tb_sram_dp_be;

    localparam int             AB     = 5;
    localparam int             DW     = 32;
    localparam int             NR     = 20;
    localparam int             BEW    = DW / 8;
    localparam logic [DW-1:0]  INIT_V = 32'h3C96_E10F;

    logic            clk = 1'b0;
    logic            rst_n, cs, we, rd, clr;
    logic [AB-1:0]   wr_addr, rd_addr;
    logic [BEW-1:0]  wr_be;
    logic [DW-1:0]   wr_data;
    logic [DW-1:0]   rd_data;
    logic            rd_valid, busy;

    always #5 clk = ~clk;

    sram_dp_be #(
        .ADDRESS_BITS (AB),
        .DATA_WIDTH   (DW),
        .NUM_REG      (NR),
        .INIT_VALUE   (INIT_V)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs       (cs),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_be    (wr_be),
        .wr_data  (wr_data),
        .rd       (rd),
        .rd_addr  (rd_addr),
        .clr      (clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    // Reference model: word array, cycles of init still to run, expected reads.
    logic [DW-1:0] ref_mem [NR];
    int            init_left = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_hold = '0;
    bit            started = 1'b0;
    int            n_cmp = 0;
    int            n_bad = 0;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                            input logic [DW-1:0] new_w,
                                            input logic [BEW-1:0] be);
        logic [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < BEW; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge: evaluate the model against the inputs being applied,
    // commit it just after the edge, then check busy.
    task automatic step();
        bit            was_reset, do_wr, push;
        int            wa, ra;
        logic [DW-1:0] wword, rexp;
        was_reset = !rst_n;
        do_wr = 1'b0; push = 1'b0; wword = '0; rexp = '0;
        wa = int'(wr_addr);
        ra = int'(rd_addr);
        if (!was_reset && init_left == 0 && cs) begin
            if (we && wa < NR) begin
                do_wr = 1'b1;
                wword = merge(ref_mem[wa], wr_data, wr_be);
            end
            if (rd) begin
                push = 1'b1;
                if (ra >= NR)                rexp = '0;
                else if (do_wr && wa == ra)  rexp = wword;
                else                         rexp = ref_mem[ra];
            end
        end
        @(posedge clk);
        if (was_reset) begin
            init_left = NR;
            exp_hold  = '0;
        end else if (init_left > 0) begin
            init_left--;
            if (init_left == 0) begin
                for (int i = 0; i < NR; i++) ref_mem[i] = INIT_V;
            end
        end else begin
            if (do_wr) ref_mem[wa] = wword;
            if (push)  exp_q.push_back(rexp);
            if (clr)   init_left = NR;
        end
        #1;
        if (started) check("busy", DW'(busy), DW'(init_left != 0));
    endtask

    // Monitor: every cycle either a valid read matches the scoreboard head,
    // or rd_data holds and nothing was expected.
    always @(negedge clk) begin
        if (started) begin
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_valid: got rd_valid=1 data %h expected rd_valid=0 at %0t", rd_data, $time);
                end else begin
                    exp_hold = exp_q.pop_front();
                    check("rd_data", rd_data, exp_hold);
                end
            end else begin
                if (exp_q.size() != 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL missing_valid: got rd_valid=0 expected rd_valid=1 data %h at %0t", exp_q[0], $time);
                    void'(exp_q.pop_front());
                end
                check("rd_hold", rd_data, exp_hold);
            end
        end
    end

    task automatic idle();
        cs = 1'b0; we = 1'b0; rd = 1'b0; clr = 1'b0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d, input logic [BEW-1:0] be);
        idle(); cs = 1'b1; we = 1'b1;
        wr_addr = AB'(a); wr_data = d; wr_be = be;
        step(); idle();
    endtask

    task automatic rdr(input int a);
        idle(); cs = 1'b1; rd = 1'b1; rd_addr = AB'(a);
        step(); idle();
    endtask

    task automatic read_all();
        for (int a = 0; a < NR; a++) rdr(a);
    endtask

    task automatic rand_cycle(input int clr_odds, input int rst_odds);
        cs      = ($urandom_range(0, 7) != 0);
        we      = $urandom_range(0, 1) == 1;
        rd      = $urandom_range(0, 1) == 1;
        wr_addr = AB'($urandom_range(0, 31));
        rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AB'($urandom_range(0, 31));
        wr_be   = BEW'($urandom_range(0, 15));
        wr_data = $urandom;
        clr     = (clr_odds > 0) && ($urandom_range(0, clr_odds - 1) == 0);
        rst_n   = !((rst_odds > 0) && ($urandom_range(0, rst_odds - 1) == 0));
        step();
    endtask

    initial begin
        rst_n = 1'b0; idle();
        wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
        // Reset for two clocks; requests during init must be ignored.
        step();
        started = 1'b1;
        check("reset_rd_data", rd_data, '0);
        check("reset_rd_valid", DW'(rd_valid), '0);
        step();
        rst_n = 1'b1;
        repeat (NR) rand_cycle(0, 0);
        idle();
        read_all();
        // Byte-enable merge and write-first collision.
        wr(3, 32'hAABB_CCDD, 4'hF);
        wr(3, 32'h1122_3344, 4'b0101);
        rdr(3);
        wr(7, 32'h0, 4'hF);
        cs = 1'b1; we = 1'b1; rd = 1'b1; wr_addr = 7; rd_addr = 7;
        wr_be = 4'b0011; wr_data = 32'hFFFF_FFFF;
        step(); idle();
        wr(9, 32'h1234_5678, 4'h0);
        rdr(9);
        // Chip select gating.
        cs = 1'b0; we = 1'b1; rd = 1'b1; wr_addr = 5; rd_addr = 5; wr_be = 4'hF; wr_data = 32'hDEAD_BEEF;
        repeat (3) step();
        idle(); rdr(5);
        // Out-of-range write and read.
        wr(25, 32'hCAFE_F00D, 4'hF);
        rdr(25);
        read_all();
        // Fill, clear, then reset in the middle of init.
        for (int a = 0; a < NR; a++) wr(a, 32'h5A5A_5A5A, 4'hF);
        clr = 1'b1; step(); idle();
        repeat (NR) step();
        read_all();
        for (int a = 0; a < NR; a++) wr(a, 32'h5A5A_5A5A, 4'hF);
        clr = 1'b1; step(); idle();
        repeat (10) step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        repeat (NR) step();
        read_all();
        // Randomised traffic, then with occasional resets.
        repeat (400) rand_cycle(50, 0);
        repeat (300) rand_cycle(60, 80);
        rst_n = 1'b1; idle();
        repeat (NR + 1) step();
        read_all();
        repeat (2) step();
        check("queue_drain", DW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
